// File: rtl/plb_bram_arb_pkg.sv
// Shared types and constants for the PLB BRAM port sequencer/arbiter.
package plb_bram_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  // One beat is one 64-bit word, so addresses advance by 8 bytes.
  localparam int unsigned BEAT_BYTES = 8;

  typedef logic req_idx_t;

  // Burst addresses wrap inside the BRAM window given by its byte size.
  function automatic logic [63:0] wrap_mask(input longint unsigned memsize);
    return 64'(memsize - 1);
  endfunction

endpackage

// File: rtl/plb_bram_port_arbiter_if.sv
// Command/data bundle for one local requester of the BRAM port arbiter.
interface plb_bram_port_arbiter_if #(
  parameter int AW  = 32,
  parameter int DW  = 64,
  parameter int NWE = 8,
  parameter int LW  = 4
) ();

  logic            Req;
  logic            RNW;
  logic [0:AW-1]   Addr;
  logic [LW-1:0]   Len;
  logic [0:NWE-1]  BE;
  logic [0:DW-1]   WrData;
  logic            Ack;
  logic            WrAck;
  logic            RdAck;

  modport master (
    output Req, RNW, Addr, Len, BE, WrData,
    input  Ack, WrAck, RdAck
  );

  modport slave (
    input  Req, RNW, Addr, Len, BE, WrData,
    output Ack, WrAck, RdAck
  );

endinterface

// File: rtl/plb_bram_rr_arb.sv
// Two-input round-robin arbiter; the pointer remembers the last winner.
module plb_bram_rr_arb
  import plb_bram_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       adv_i,
  output logic       gnt_vld_o,
  output req_idx_t   gnt_idx_o
);

  req_idx_t last_q, last_d;

  always_comb begin
    gnt_vld_o = |req_i;
    // Under contention the requester not granted last time wins.
    if (req_i == 2'b11) gnt_idx_o = ~last_q;
    else                gnt_idx_o = req_i[1];
    last_d = last_q;
    if (adv_i && gnt_vld_o) last_d = gnt_idx_o;
  end

  // Reset value 1 makes M0 the favoured requester.
  always_ff @(posedge clk_i) begin
    if (rst_i) last_q <= 1'b1;
    else       last_q <= last_d;
  end

endmodule

// File: rtl/plb_bram_port_arbiter.sv
// Round-robin sequencer for one 64-bit BRAM port shared by two requesters:
// single/burst reads and writes, one beat per cycle, read data one cycle late.
module plb_bram_port_arbiter
  import plb_bram_arb_pkg::*;
#(
  parameter int          C_PORT_AWIDTH = 32,
  parameter int          C_PORT_DWIDTH = 64,
  parameter int          C_NUM_WE      = 8,
  parameter int unsigned C_MEMSIZE     = 'h4000,
  parameter int          C_LEN_W       = 4
) (
  input  logic                     BRAM_Clk,
  input  logic                     BRAM_Rst,
  plb_bram_port_arbiter_if.slave   M0,
  plb_bram_port_arbiter_if.slave   M1,
  output logic [0:C_PORT_DWIDTH-1] Rd_Data,
  output logic                     BRAM_EN,
  output logic [0:C_NUM_WE-1]      BRAM_WEN,
  output logic [0:C_PORT_AWIDTH-1] BRAM_Addr,
  output logic [0:C_PORT_DWIDTH-1] BRAM_Dout,
  input  logic [0:C_PORT_DWIDTH-1] BRAM_Din,
  output logic                     Busy
);

  localparam logic [0:0] S_IDLE = 1'(IDLE);
  localparam logic [0:0] S_XFER = 1'(XFER);

  localparam logic [0:C_PORT_AWIDTH-1] WRAP_M  = C_PORT_AWIDTH'(wrap_mask(64'(C_MEMSIZE)));
  localparam logic [0:C_PORT_AWIDTH-1] STRIDE  = C_PORT_AWIDTH'(BEAT_BYTES);
  localparam logic [0:C_PORT_AWIDTH-1] ALIGN_M = ~(C_PORT_AWIDTH'(BEAT_BYTES - 1));

  logic [0:0]               state_q, state_d;
  req_idx_t                 gnt_q, gnt_d;
  logic                     rnw_q, rnw_d;
  logic [C_LEN_W-1:0]       len_q, len_d;
  logic [C_LEN_W-1:0]       beat_q, beat_d;
  logic [0:C_NUM_WE-1]      be_q, be_d;
  logic [0:C_PORT_AWIDTH-1] addr_q, addr_d;
  logic                     en_q, en_d;
  logic [0:C_NUM_WE-1]      wen_q, wen_d;
  logic                     ack_q, ack_d;
  logic                     rd_q, rd_d;
  req_idx_t                 rd_gnt_q, rd_gnt_d;

  logic                     arb_vld;
  req_idx_t                 arb_idx;
  logic                     win_rnw;
  logic [0:C_PORT_AWIDTH-1] win_addr;
  logic [C_LEN_W-1:0]       win_len;
  logic [0:C_NUM_WE-1]      win_be;
  logic [0:C_PORT_AWIDTH-1] addr_nxt;
  logic                     wr_act;

  plb_bram_rr_arb u_rr (
    .clk_i     (BRAM_Clk),
    .rst_i     (BRAM_Rst),
    .req_i     ({M1.Req, M0.Req}),
    .adv_i     (state_q == S_IDLE),
    .gnt_vld_o (arb_vld),
    .gnt_idx_o (arb_idx)
  );

  assign win_rnw  = arb_idx ? M1.RNW  : M0.RNW;
  assign win_addr = arb_idx ? M1.Addr : M0.Addr;
  assign win_len  = arb_idx ? M1.Len  : M0.Len;
  assign win_be   = arb_idx ? M1.BE   : M0.BE;

  // Only the bits inside the BRAM window advance; the upper bits hold.
  assign addr_nxt = (addr_q & ~WRAP_M) | ((addr_q + STRIDE) & WRAP_M);

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rnw_d    = rnw_q;
    len_d    = len_q;
    beat_d   = beat_q;
    be_d     = be_q;
    addr_d   = addr_q;
    en_d     = en_q;
    wen_d    = wen_q;
    ack_d    = 1'b0;
    rd_d     = (state_q == S_XFER) && rnw_q;
    rd_gnt_d = gnt_q;

    case (state_q)
      S_IDLE: begin
        if (arb_vld) begin
          state_d = S_XFER;
          gnt_d   = arb_idx;
          rnw_d   = win_rnw;
          len_d   = win_len;
          be_d    = win_be;
          beat_d  = '0;
          addr_d  = win_addr & ALIGN_M;
          en_d    = 1'b1;
          wen_d   = win_rnw ? '0 : win_be;
          ack_d   = 1'b1;
        end
      end
      default: begin
        if (beat_q == len_q) begin
          state_d = S_IDLE;
          en_d    = 1'b0;
          wen_d   = '0;
        end else begin
          beat_d  = beat_q + C_LEN_W'(1);
          addr_d  = addr_nxt;
          wen_d   = rnw_q ? '0 : be_q;
        end
      end
    endcase
  end

  // Command/address stage; the read-ack delay stage sits alongside it.
  always_ff @(posedge BRAM_Clk) begin
    if (BRAM_Rst) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      addr_q  <= '0;
      en_q    <= 1'b0;
      wen_q   <= '0;
      ack_q   <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      en_q    <= en_d;
      wen_q   <= wen_d;
      ack_q   <= ack_d;
      rd_q    <= rd_d;
    end
    gnt_q    <= gnt_d;
    rnw_q    <= rnw_d;
    len_q    <= len_d;
    be_q     <= be_d;
    rd_gnt_q <= rd_gnt_d;
  end

  assign wr_act    = (state_q == S_XFER) && !rnw_q;
  assign BRAM_EN   = en_q;
  assign BRAM_WEN  = wen_q;
  assign BRAM_Addr = addr_q;
  assign BRAM_Dout = wr_act ? (gnt_q ? M1.WrData : M0.WrData) : '0;
  assign Rd_Data   = BRAM_Din;
  assign Busy      = (state_q == S_XFER);

  assign M0.Ack   = ack_q && !gnt_q;
  assign M1.Ack   = ack_q && gnt_q;
  assign M0.WrAck = wr_act && !gnt_q;
  assign M1.WrAck = wr_act && gnt_q;
  assign M0.RdAck = rd_q && !rd_gnt_q;
  assign M1.RdAck = rd_q && rd_gnt_q;

endmodule

// File: tb/tb_plb_bram_port_arbiter.sv
// Directed bench for plb_bram_port_arbiter with a behavioural 64-bit BRAM.
module tb_plb_bram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] rd_data;
  logic        en;
  logic [7:0]  wen;
  logic [31:0] baddr;
  logic [63:0] dout;
  logic [63:0] din = '0;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  plb_bram_port_arbiter_if m0 ();
  plb_bram_port_arbiter_if m1 ();

  plb_bram_port_arbiter dut (
    .BRAM_Clk  (clk),
    .BRAM_Rst  (rst),
    .M0        (m0),
    .M1        (m1),
    .Rd_Data   (rd_data),
    .BRAM_EN   (en),
    .BRAM_WEN  (wen),
    .BRAM_Addr (baddr),
    .BRAM_Dout (dout),
    .BRAM_Din  (din),
    .Busy      (busy)
  );

  always #5 clk = ~clk;

  // Unwritten words read back a pattern derived from their index.
  function automatic logic [63:0] pat(input logic [10:0] i);
    return {21'h1ADA, i, 21'h0F0F, i};
  endfunction

  function automatic logic [63:0] wdat(input int k);
    return 64'hFEED_0000_0000_0000 | 64'(k);
  endfunction

  logic [63:0]   mem [0:2047];
  logic [2047:0] written;
  logic          mem_clr;

  always @(posedge clk) begin
    if (mem_clr) written <= '0;
    else if (en) begin
      for (int j = 0; j < 8; j++)
        if (wen[j]) mem[baddr[13:3]][8*j +: 8] <= dout[8*j +: 8];
      if (wen != 8'h00) written[baddr[13:3]] <= 1'b1;
      din <= written[baddr[13:3]] ? mem[baddr[13:3]] : pat(baddr[13:3]);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int n, input logic rnw, input logic [31:0] a,
                     input logic [3:0] len, input logic [7:0] be, input logic [63:0] wd);
    if (n == 0) begin
      m0.Req = 1'b1; m0.RNW = rnw; m0.Addr = a; m0.Len = len; m0.BE = be; m0.WrData = wd;
    end else begin
      m1.Req = 1'b1; m1.RNW = rnw; m1.Addr = a; m1.Len = len; m1.BE = be; m1.WrData = wd;
    end
  endtask

  task automatic drop(input int n);
    if (n == 0) m0.Req = 1'b0;
    else        m1.Req = 1'b0;
  endtask

  logic [31:0] wrap_a [4] = '{32'h3FF0, 32'h3FF8, 32'h0000, 32'h0008};
  int n_en, n_rd;

  initial begin
    rst = 1'b1; mem_clr = 1'b1;
    m0.Req = 0; m0.RNW = 0; m0.Addr = '0; m0.Len = '0; m0.BE = '0; m0.WrData = '0;
    m1.Req = 0; m1.RNW = 0; m1.Addr = '0; m1.Len = '0; m1.BE = '0; m1.WrData = '0;
    tick(); tick();
    rst = 1'b0; mem_clr = 1'b0;
    #1;
    check("rst_en",   en, 0);
    check("rst_wen",  wen, 0);
    check("rst_addr", baddr, 0);
    check("rst_dout", dout, 0);
    check("rst_busy", busy, 0);
    check("rst_acks", {m0.Ack, m1.Ack, m0.WrAck, m1.WrAck, m0.RdAck, m1.RdAck}, 0);

    // M0 single write, then M1 single read of the same word
    req(0, 1'b0, 32'h100, 4'd0, 8'hFF, 64'h0123456789ABCDEF);
    tick();
    check("t1_ack0", m0.Ack, 1);
    check("t1_ack1", m1.Ack, 0);
    check("t1_en", en, 1);
    check("t1_wen", wen, 8'hFF);
    check("t1_addr", baddr, 32'h100);
    check("t1_wrack0", m0.WrAck, 1);
    check("t1_dout", dout, 64'h0123456789ABCDEF);
    check("t1_busy", busy, 1);
    drop(0);
    tick();
    check("t1_idle_en", en, 0);
    check("t1_idle_ack0", m0.Ack, 0);
    check("t1_idle_busy", busy, 0);
    req(1, 1'b1, 32'h100, 4'd0, 8'h00, 64'h0);
    tick();
    check("t1r_ack1", m1.Ack, 1);
    check("t1r_wen", wen, 0);
    check("t1r_addr", baddr, 32'h100);
    check("t1r_rdack1_early", m1.RdAck, 0);
    drop(1);
    tick();
    check("t1r_rdack1", m1.RdAck, 1);
    check("t1r_rdack0", m0.RdAck, 0);
    check("t1r_data", rd_data, 64'h0123456789ABCDEF);

    // Simultaneous 4-beat reads: M0 favoured first
    req(0, 1'b1, 32'h200, 4'd3, 8'h00, 64'h0);
    req(1, 1'b1, 32'h300, 4'd3, 8'h00, 64'h0);
    tick();
    check("t2_ack0", m0.Ack, 1);
    check("t2_ack1", m1.Ack, 0);
    check("t2_addr0", baddr, 32'h200);
    drop(0);
    for (int k = 1; k < 4; k++) begin
      tick();
      check("t2_addr", baddr, 32'h200 + 32'(8 * k));
      check("t2_rdack0", m0.RdAck, 1);
      check("t2_rd0", rd_data, pat(11'h40 + 11'(k - 1)));
    end
    tick();
    check("t2_gap_busy", busy, 0);
    check("t2_gap_en", en, 0);
    check("t2_last_rdack0", m0.RdAck, 1);
    check("t2_last_rd0", rd_data, pat(11'h43));
    tick();
    check("t2_ack1_late", m1.Ack, 1);
    check("t2_addr1", baddr, 32'h300);
    check("t2_rdack0_off", m0.RdAck, 0);
    drop(1);
    for (int k = 1; k < 4; k++) begin
      tick();
      check("t2_addr_m1", baddr, 32'h300 + 32'(8 * k));
      check("t2_rd1", rd_data, pat(11'h60 + 11'(k - 1)));
    end
    tick();
    check("t2_last_rdack1", m1.RdAck, 1);
    check("t2_last_rd1", rd_data, pat(11'h63));

    // M0 wrapping write burst
    req(0, 1'b0, 32'h3FF0, 4'd3, 8'hFF, wdat(0));
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t3_addr", baddr, wrap_a[k]);
      check("t3_wrack0", m0.WrAck, 1);
      check("t3_wrack1", m1.WrAck, 0);
      check("t3_dout", dout, wdat(k));
      if (k == 0) drop(0);
      m0.WrData = wdat(k + 1);
    end
    tick();
    check("t3_end_wrack0", m0.WrAck, 0);
    check("t3_end_busy", busy, 0);

    // Simultaneous reads again: M0 was granted last, so M1 goes first
    req(0, 1'b1, 32'h200, 4'd3, 8'h00, 64'h0);
    req(1, 1'b1, 32'h300, 4'd3, 8'h00, 64'h0);
    tick();
    check("t2b_ack1", m1.Ack, 1);
    check("t2b_ack0", m0.Ack, 0);
    check("t2b_addr", baddr, 32'h300);
    drop(1);
    tick(); tick(); tick(); tick();
    check("t2b_gap_busy", busy, 0);
    tick();
    check("t2b_ack0_late", m0.Ack, 1);
    check("t2b_addr0", baddr, 32'h200);
    drop(0);
    tick(); tick(); tick(); tick();

    // Partial write over an all-ones word
    req(1, 1'b0, 32'h400, 4'd0, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
    tick(); drop(1); tick();
    req(1, 1'b0, 32'h404, 4'd0, 8'h0F, 64'h0123456789ABCDEF);
    tick();
    check("t4_addr_aligned", baddr, 32'h400);
    check("t4_wen", wen, 8'h0F);
    drop(1); tick();
    req(1, 1'b1, 32'h400, 4'd0, 8'h00, 64'h0);
    tick(); drop(1); tick();
    check("t4_rdack1", m1.RdAck, 1);
    check("t4_data", rd_data, 64'hFFFF_FFFF_89AB_CDEF);

    // Reset during beat 2 of a 16-beat read
    req(0, 1'b1, 32'h800, 4'd15, 8'h00, 64'h0);
    tick(); drop(0);
    tick(); tick();
    check("t5_beat2_addr", baddr, 32'h810);
    rst = 1'b1;
    tick();
    check("t5_en", en, 0);
    check("t5_wen", wen, 0);
    check("t5_rdack0", m0.RdAck, 0);
    check("t5_busy", busy, 0);
    rst = 1'b0;
    req(1, 1'b1, 32'h100, 4'd0, 8'h00, 64'h0);
    tick();
    check("t5_ack1", m1.Ack, 1);
    check("t5_addr", baddr, 32'h100);
    drop(1);
    tick();
    check("t5_rdack1", m1.RdAck, 1);
    check("t5_rdack0", m0.RdAck, 0);
    check("t5_data", rd_data, 64'h0123456789ABCDEF);

    // Req dropped mid-burst still yields all beats
    n_en = 0; n_rd = 0;
    req(0, 1'b1, 32'h200, 4'd5, 8'h00, 64'h0);
    for (int c = 0; c < 12; c++) begin
      tick();
      if (en) n_en++;
      if (m0.RdAck) n_rd++;
      if (c == 2) drop(0);
    end
    check("t6_beats", 64'(n_en), 6);
    check("t6_rdacks", 64'(n_rd), 6);
    check("t6_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/plb_bram_port_arbiter.md
# plb_bram_port_arbiter

Sequencer and two-way arbiter for one port of the dual-port 64-bit PLB BRAM block. It accepts single or burst read/write commands from two local requesters (M0, M1) and grants them round-robin. It then drives the BRAM port's enable, byte write-enables, address and write data one beat per cycle, and returns read data with the BRAM's one-cycle latency. It sits between requester logic and either port A or port B of the BRAM elaboration.

## Interface
Parameters:
- C_PORT_AWIDTH, 32, BRAM address width, big-endian bit numbering [0:AW-1].
- C_PORT_DWIDTH, 64, data width; one beat is one 8-byte word.
- C_NUM_WE, 8, byte write-enable width.
- C_MEMSIZE, 'h4000, BRAM size in bytes, power of two; sets the burst wrap window.
- C_LEN_W, 4, burst length field width; beats = Len+1 (1..16).

Ports (n = 0,1; one independent set per requester):
- BRAM_Clk  in  1  sole clock; all state updates on rising edge.
- BRAM_Rst  in  1  reset; synchronous and active-high.
- Mn_Req  in  1  command valid; held until Mn_Ack.
- Mn_RNW  in  1  1 = read, 0 = write.
- Mn_Addr  in  C_PORT_AWIDTH  start byte address; bits [AW-3:AW-1] ignored (treated 0).
- Mn_Len  in  C_LEN_W  beats minus one.
- Mn_BE  in  C_NUM_WE  byte enables applied to every write beat.
- Mn_Ack  out  1  one-cycle pulse: command accepted, first beat issued.
- Mn_WrData  in  C_PORT_DWIDTH  current write word; consumed when Mn_WrAck=1.
- Mn_WrAck  out  1  write beat consumed this cycle.
- Mn_RdAck  out  1  Rd_Data valid for Mn this cycle.
- Rd_Data  out  C_PORT_DWIDTH  shared read data, equal to BRAM_Din.
- BRAM_EN  out  1  port enable.
- BRAM_WEN  out  C_NUM_WE  byte write enables.
- BRAM_Addr  out  C_PORT_AWIDTH  port byte address, low 3 bits 0.
- BRAM_Dout  out  C_PORT_DWIDTH  write data to BRAM.
- BRAM_Din  in  C_PORT_DWIDTH  read data from BRAM, valid one cycle after a read-enable cycle.
- Busy  out  1  state is XFER.

## Operation
- FSM states IDLE and XFER.
- **IDLE:** if any Mn_Req=1, the round-robin picks a winner. The winner's RNW, Addr (low 3 bits cleared), Len and BE are registered, the beat counter clears, and the state becomes XFER on the next edge. Mn_Ack is asserted in the first XFER cycle.
- **Round-robin:** a last-grant pointer favours the requester not granted most recently. After reset, M0 is favoured. With one request pending, it wins unconditionally.
- **XFER:** every cycle, BRAM_EN=1 and BRAM_Addr = base + 8*beat.
  - Only the low log2(C_MEMSIZE) address bits increment, so the burst wraps inside the BRAM window; the upper bits hold.
  - Write: BRAM_WEN=BE, BRAM_Dout=Mn_WrData of the granted requester, and Mn_WrAck=1 in the same cycle. The requester advances its word on WrAck.
  - Read: BRAM_WEN=0, and Mn_RdAck=1 in the following cycle.
  - When beat == Len, the state returns to IDLE on the next edge.
- Mn_Req dropped mid-burst is ignored; the burst always completes. A Req still held at IDLE is re-arbitrated.
- The IDLE cycle between bursts is mandatory: the minimum gap is one cycle.
- The non-granted requester's Ack, WrAck and RdAck stay 0.

## Timing
- Reset values: every output is 0, the state is IDLE, and the pointer favours M0.
- Req sampled in cycle t gives Ack, first BRAM_EN and first address in t+1. An L-beat burst occupies t+1..t+L.
- Read data: RdAck and Rd_Data for beat k arrive one cycle after beat k's enable. The last RdAck lands in the IDLE cycle, or in the first cycle of the next grant; it is pipelined independently of the FSM.
- BRAM_Rst mid-burst:
  - the FSM goes to IDLE and the beat counter clears;
  - the in-flight RdAck is suppressed;
  - BRAM_EN/WEN are 0 in the following cycle.
- BRAM_EN, BRAM_WEN, BRAM_Addr and Mn_Ack are driven from registers. BRAM_Dout, Mn_WrAck and Rd_Data are combinational.

## Structure
- Package plb_bram_arb_pkg:
  - state enum {IDLE, XFER};
  - beat byte stride constant 8;
  - wrap-mask function of C_MEMSIZE;
  - requester index type.
- One sub-module, plb_bram_rr_arb: a two-input round-robin arbiter with a pointer register, advanced only on grant.
- Top level holds the FSM, command registers, beat counter, address generator and the read-ack delay register.

## Test plan
- M0 single write, Addr 0x100, BE 0xFF, data 0x0123456789ABCDEF → Ack0 and EN/WEN=0xFF, Addr 0x100 in the next cycle. A subsequent M1 single read of 0x100 returns that word with RdAck1 one cycle after EN.
- M0 and M1 request in the same cycle, both 4-beat reads → M0 served first and M1 starts after one IDLE cycle. Repeating the simultaneous requests gives M1 first.
- Write burst Len=3, Addr 0x3FF0, C_MEMSIZE 'h4000 → addresses 0x3FF0, 0x3FF8, 0x0000, 0x0008. WrAck0 is asserted on 4 consecutive cycles.
- Partial write with BE 0x0F over 0xFF..FF, then read → only bytes 4..7 (big-endian lanes) change.
- BRAM_Rst asserted on beat 2 of a 16-beat read → the next cycle has EN=0, RdAck=0 and Busy=0. A new M1 request is granted normally after reset drops.
- M0 drops Req mid-burst → all Len+1 beats still issue and the burst completes.
